// File: rtl/nd_router_1to2_pkg.sv
// Shared sizes, compare operators and state encodings for the 1-to-2 router.
// The range compare helper decides which output a destination goes to.
package nd_router_1to2_pkg;

    localparam int NS_ADDRESS_SIZE = 6;
    localparam int NS_DATA_SIZE    = 4;
    localparam int NS_REDUN_SIZE   = 4;

    localparam bit NS_TRUE  = 1'b1;
    localparam bit NS_FALSE = 1'b0;
    localparam bit NS_ON    = 1'b1;
    localparam bit NS_OFF   = 1'b0;

    typedef enum logic [2:0] {
        NS_GT_OP,
        NS_GTE_OP,
        NS_LT_OP,
        NS_LTE_OP,
        NS_EQ_OP,
        NS_NE_OP
    } ns_op_t;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_ACKH,
        IN_ACKL
    } in_st_t;

    typedef enum logic [1:0] {
        OB_EMPTY,
        OB_FULL,
        OB_DROP
    } ob_st_t;

    function automatic logic ns_cmp_op(
        input ns_op_t      op,
        input logic [31:0] rv,
        input logic [31:0] val
    );
        logic r;
        r = 1'b0;
        unique case (op)
            NS_GT_OP:  r = (val > rv);
            NS_GTE_OP: r = (val >= rv);
            NS_LT_OP:  r = (val < rv);
            NS_LTE_OP: r = (val <= rv);
            NS_EQ_OP:  r = (val == rv);
            NS_NE_OP:  r = (val != rv);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Second operand only matters when the test is a range.
    function automatic logic ns_range_cmp_op(
        input logic        is_range,
        input ns_op_t      op1,
        input logic [31:0] rv1,
        input logic [31:0] v1,
        input ns_op_t      op2,
        input logic [31:0] rv2,
        input logic [31:0] v2
    );
        return ns_cmp_op(op1, rv1, v1) &&
               (!is_range || ns_cmp_op(op2, rv2, v2));
    endfunction

endpackage

// File: rtl/nd_router_1to2_out_buf.sv
// One-entry holding register plus 4-phase output handshake FSM.
// Fields hold their last value after the downstream ack.
module nd_out_buf
    import nd_router_1to2_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic [ASZ-1:0] i_src,
    input  logic [ASZ-1:0] i_dst,
    input  logic [DSZ-1:0] i_dat,
    input  logic [RSZ-1:0] i_red,
    output logic           o_empty,
    output logic [ASZ-1:0] o_src,
    output logic [ASZ-1:0] o_dst,
    output logic [DSZ-1:0] o_dat,
    output logic [RSZ-1:0] o_red,
    output logic           o_req,
    input  logic           i_ack
);

    ob_st_t         r_st;
    logic           r_req;
    logic [ASZ-1:0] r_src;
    logic [ASZ-1:0] r_dst;
    logic [DSZ-1:0] r_dat;
    logic [RSZ-1:0] r_red;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st  <= OB_EMPTY;
            r_req <= 1'b0;
            r_src <= '0;
            r_dst <= '0;
            r_dat <= '0;
            r_red <= '0;
        end else begin
            unique case (r_st)
                OB_EMPTY: begin
                    if (i_load) begin
                        r_src <= i_src;
                        r_dst <= i_dst;
                        r_dat <= i_dat;
                        r_red <= i_red;
                        r_req <= 1'b1;
                        r_st  <= OB_FULL;
                    end
                end
                OB_FULL: begin
                    if (i_ack) begin
                        r_req <= 1'b0;
                        r_st  <= OB_DROP;
                    end
                end
                OB_DROP: begin
                    if (!i_ack) begin
                        r_st <= OB_EMPTY;
                    end
                end
                default: begin
                    r_req <= 1'b0;
                    r_st  <= OB_EMPTY;
                end
            endcase
        end
    end

    assign o_empty = (r_st == OB_EMPTY);
    assign o_req   = r_req;
    assign o_src   = r_src;
    assign o_dst   = r_dst;
    assign o_dat   = r_dat;
    assign o_red   = r_red;

endmodule

// File: rtl/nd_router_1to2.sv
// Routing node: one 4-phase input channel steered to one of two buffered
// outputs by a parameterised compare on the destination address.
module nd_router_1to2
    import nd_router_1to2_pkg::*;
#(
    parameter ns_op_t      OPER_1    = NS_GT_OP,
    parameter logic [31:0] REF_VAL_1 = '0,
    parameter bit          IS_RANGE  = NS_FALSE,
    parameter ns_op_t      OPER_2    = NS_GT_OP,
    parameter logic [31:0] REF_VAL_2 = '0,
    parameter int          ASZ       = NS_ADDRESS_SIZE,
    parameter int          DSZ       = NS_DATA_SIZE,
    parameter int          RSZ       = NS_REDUN_SIZE
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [ASZ-1:0] o1_src,
    output logic [ASZ-1:0] o1_dst,
    output logic [DSZ-1:0] o1_dat,
    output logic [RSZ-1:0] o1_red,
    output logic           o1_req,
    input  logic           o1_ack
);

    in_st_t r_st;
    logic   r_ack;
    logic   w_sel0;
    logic   w_empty0;
    logic   w_empty1;
    logic   w_take;
    logic   w_load0;
    logic   w_load1;

    assign w_sel0 = ns_range_cmp_op(IS_RANGE,
                                    OPER_1, REF_VAL_1, 32'(i0_dst),
                                    OPER_2, REF_VAL_2, 32'(i0_dst));

    // A full target buffer parks the message on the input without acking.
    assign w_take  = (r_st == IN_IDLE) && i0_req && !r_ack;
    assign w_load0 = w_take && w_sel0 && w_empty0;
    assign w_load1 = w_take && !w_sel0 && w_empty1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st  <= IN_IDLE;
            r_ack <= 1'b0;
        end else begin
            unique case (r_st)
                IN_IDLE: begin
                    if (w_load0 || w_load1) begin
                        r_ack <= 1'b1;
                        r_st  <= IN_ACKH;
                    end
                end
                IN_ACKH: begin
                    if (!i0_req) begin
                        r_ack <= 1'b0;
                        r_st  <= IN_ACKL;
                    end
                end
                IN_ACKL: r_st <= IN_IDLE;
                default: begin
                    r_ack <= 1'b0;
                    r_st  <= IN_IDLE;
                end
            endcase
        end
    end

    assign i0_ack = r_ack;

    nd_out_buf #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_buf0 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load0),
        .i_src   (i0_src),
        .i_dst   (i0_dst),
        .i_dat   (i0_dat),
        .i_red   (i0_red),
        .o_empty (w_empty0),
        .o_src   (o0_src),
        .o_dst   (o0_dst),
        .o_dat   (o0_dat),
        .o_red   (o0_red),
        .o_req   (o0_req),
        .i_ack   (o0_ack)
    );

    nd_out_buf #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_buf1 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load1),
        .i_src   (i0_src),
        .i_dst   (i0_dst),
        .i_dat   (i0_dat),
        .i_red   (i0_red),
        .o_empty (w_empty1),
        .o_src   (o1_src),
        .o_dst   (o1_dst),
        .o_dat   (o1_dat),
        .o_red   (o1_red),
        .o_req   (o1_req),
        .i_ack   (o1_ack)
    );

endmodule

// File: tb/tb_nd_router_1to2.sv
// Scoreboard bench: a default-parameter router and a range router
// (GT 1 AND LT 3) driven by directed vectors.
module tb_nd_router_1to2;
    import nd_router_1to2_pkg::*;

    localparam int A = NS_ADDRESS_SIZE;
    localparam int D = NS_DATA_SIZE;
    localparam int R = NS_REDUN_SIZE;
    localparam int W = 2 * A + D + R;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // unit 0 = default router, unit 1 = range router
    logic [A-1:0] in_src[2];
    logic [A-1:0] in_dst[2];
    logic [D-1:0] in_dat[2];
    logic [R-1:0] in_red[2];
    logic         in_req[2];
    logic         in_ack[2];

    // channel 0/1 = default o0/o1, channel 2/3 = range o0/o1
    logic [A-1:0] o_src[4];
    logic [A-1:0] o_dst[4];
    logic [D-1:0] o_dat[4];
    logic [R-1:0] o_red[4];
    logic         o_req[4];
    bit           o_ack[4];
    bit           en[4];

    logic [W-1:0] exp_q[4][$];
    int checks = 0;
    int errors = 0;

    nd_router_1to2 dut_d (
        .clk(clk), .reset(rst_n),
        .i0_src(in_src[0]), .i0_dst(in_dst[0]),
        .i0_dat(in_dat[0]), .i0_red(in_red[0]),
        .i0_req(in_req[0]), .i0_ack(in_ack[0]),
        .o0_src(o_src[0]), .o0_dst(o_dst[0]),
        .o0_dat(o_dat[0]), .o0_red(o_red[0]),
        .o0_req(o_req[0]), .o0_ack(o_ack[0]),
        .o1_src(o_src[1]), .o1_dst(o_dst[1]),
        .o1_dat(o_dat[1]), .o1_red(o_red[1]),
        .o1_req(o_req[1]), .o1_ack(o_ack[1])
    );

    nd_router_1to2 #(
        .OPER_1(NS_GT_OP), .REF_VAL_1(32'd1), .IS_RANGE(NS_TRUE),
        .OPER_2(NS_LT_OP), .REF_VAL_2(32'd3)
    ) dut_r (
        .clk(clk), .reset(rst_n),
        .i0_src(in_src[1]), .i0_dst(in_dst[1]),
        .i0_dat(in_dat[1]), .i0_red(in_red[1]),
        .i0_req(in_req[1]), .i0_ack(in_ack[1]),
        .o0_src(o_src[2]), .o0_dst(o_dst[2]),
        .o0_dat(o_dat[2]), .o0_red(o_red[2]),
        .o0_req(o_req[2]), .o0_ack(o_ack[2]),
        .o1_src(o_src[3]), .o1_dst(o_dst[3]),
        .o1_dat(o_dat[3]), .o1_red(o_red[3]),
        .o1_req(o_req[3]), .o1_ack(o_ack[3])
    );

    // Sink + monitor: pops the expected message when a request is accepted.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (!rst_n) begin
                o_ack[c] = 1'b0;
            end else if (o_req[c] && !o_ack[c] && en[c]) begin
                logic [W-1:0] got;
                logic [W-1:0] e;
                got = {o_src[c], o_dst[c], o_dat[c], o_red[c]};
                checks++;
                if (exp_q[c].size() == 0) begin
                    errors++;
                    $display("FAIL ch%0d_unexpected got=%h required=none",
                             c, got);
                end else begin
                    e = exp_q[c].pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL ch%0d_msg got=%h required=%h",
                                 c, got, e);
                    end
                end
                o_ack[c] = 1'b1;
            end else if (o_ack[c] && !o_req[c]) begin
                o_ack[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    task automatic send(input int u, input int ch,
                        input logic [A-1:0] src, input logic [A-1:0] dst,
                        input logic [D-1:0] dat, input logic [R-1:0] red,
                        output int lat);
        int n;
        exp_q[ch].push_back({src, dst, dat, red});
        in_src[u] = src;
        in_dst[u] = dst;
        in_dat[u] = dat;
        in_red[u] = red;
        in_req[u] = 1'b1;
        lat = 0;
        while (in_ack[u] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (in_ack[u] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL u%0d_ack_rise_timeout got=0 required=1", u);
        end
        in_req[u] = 1'b0;
        n = 0;
        while (in_ack[u] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (in_ack[u] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL u%0d_ack_fall_timeout got=1 required=0", u);
        end
    endtask

    function automatic int pending();
        return exp_q[0].size() + exp_q[1].size() +
               exp_q[2].size() + exp_q[3].size();
    endfunction

    initial begin
        int lat;
        int n;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_src[u] = '0;
            in_dst[u] = '0;
            in_dat[u] = '0;
            in_red[u] = '0;
            in_req[u] = 1'b0;
        end
        for (int c = 0; c < 4; c++) en[c] = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_i0_ack_d", int'(in_ack[0]), 0);
        chk("rst_i0_ack_r", int'(in_ack[1]), 0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst_req%0d", c), int'(o_req[c]), 0);
            chk($sformatf("rst_fields%0d", c),
                int'({o_src[c], o_dst[c], o_dat[c], o_red[c]}), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // default router: GT 0
        en[0] = 1'b0;
        send(0, 0, 6'd3, 6'd1, 4'd5, 4'hA, lat);
        chk("t1_ack_latency", lat, 1);
        chk("t1_o0_req", int'(o_req[0]), 1);
        chk("t1_o1_idle", int'(o_req[1]), 0);
        en[0] = 1'b1;
        send(0, 1, 6'd4, 6'd0, 4'd7, 4'h3, lat);
        send(0, 0, 6'd5, 6'd63, 4'd9, 4'hF, lat);

        // range router: GT 1 AND LT 3
        send(1, 2, 6'd1, 6'd2, 4'd1, 4'h1, lat);
        send(1, 3, 6'd1, 6'd1, 4'd2, 4'h2, lat);
        send(1, 3, 6'd1, 6'd3, 4'd3, 4'h3, lat);
        send(1, 3, 6'd1, 6'd0, 4'd4, 4'h4, lat);

        // o0 stalled: second dst=2 blocks the input and the later dst=1
        n = 0;
        while (pending() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        en[2] = 1'b0;
        fork
            begin
                send(1, 2, 6'd2, 6'd2, 4'd10, 4'h6, lat);
                send(1, 2, 6'd2, 6'd2, 4'd11, 4'h7, lat);
                send(1, 3, 6'd2, 6'd1, 4'd12, 4'h8, lat);
            end
            begin
                repeat (20) @(negedge clk);
                chk("stall_i0_ack", int'(in_ack[1]), 0);
                chk("stall_o0_req", int'(o_req[2]), 1);
                chk("stall_o1_idle", int'(o_req[3]), 0);
                chk("stall_o0_first", int'(o_dat[2]), 10);
                en[2] = 1'b1;
            end
        join

        // back-to-back alternating routes
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0)
                send(1, 2, 6'd9, 6'd2, 4'(i % 16), 4'(i / 2), lat);
            else
                send(1, 3, 6'd9, 6'd1, 4'(i % 16), 4'(i / 2), lat);
        end
        n = 0;
        while (pending() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drained", pending(), 0);

        // reset while o1 of the range router is requesting
        en[3] = 1'b0;
        send(1, 3, 6'd7, 6'd1, 4'd9, 4'h5, lat);
        n = 0;
        while (o_req[3] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_o1_req", int'(o_req[3]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_o1_req", int'(o_req[3]), 0);
        chk("rst_i0_ack", int'(in_ack[1]), 0);
        chk("rst_o1_fields",
            int'({o_src[3], o_dst[3], o_dat[3], o_red[3]}), 0);
        chk("rst_o0_fields",
            int'({o_src[2], o_dst[2], o_dat[2], o_red[2]}), 0);
        exp_q[3].delete();
        en[3] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1, 3, 6'd8, 6'd1, 4'd4, 4'h9, lat);
        chk("post_rst_ack_latency_ok", int'(lat <= 2), 1);
        send(1, 2, 6'd8, 6'd2, 4'd6, 4'hB, lat);

        n = 0;
        while (pending() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("final_drained", pending(), 0);
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
